// File: rtl/value_fifo_if.sv
// Value stream bundle around value_fifo: upstream value/valid/ready,
// downstream value/valid/ready, plus occupancy and high-water mark.
interface value_fifo_if #(
    parameter int BITS  = 8,
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [BITS-1:0]  in_value;
    logic             in_valid;
    logic             in_ready;
    logic [BITS-1:0]  out_value;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] peak;

    // Producer/consumer side that drives the FIFO.
    modport master (
        output in_value, in_valid, out_ready,
        input  in_ready, out_value, out_valid, count, peak
    );

    // The FIFO itself.
    modport slave (
        input  in_value, in_valid, out_ready,
        output in_ready, out_value, out_valid, count, peak
    );
endinterface

// File: rtl/value_fifo.sv
// First-word-fall-through FIFO: registered storage and pointers, occupancy held
// in its own counter, sticky high-water mark. Only reset reaches in_ready combinationally.
module value_fifo #(
    parameter int BITS  = 8,
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    value_fifo_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [BITS-1:0]  mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] peak_r;
    logic [CNT_W-1:0] count_next_s;
    logic [CNT_W-1:0] peak_next_s;
    logic [BITS-1:0]  out_value_s;
    logic             in_ready_s;
    logic             out_valid_s;
    logic             push_s;
    logic             pop_s;

    function automatic logic [CNT_W-1:0] max_cnt(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    // Full-ness alone gates acceptance, so a pop never frees a slot in the same cycle.
    assign in_ready_s  = (count_r != CNT_W'(DEPTH)) && !reset;
    assign out_valid_s = (count_r != {CNT_W{1'b0}});
    assign push_s      = bus.in_valid && in_ready_s;
    assign pop_s       = out_valid_s && bus.out_ready;

    // Occupancy and high-water mark for the coming edge.
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_W'(1);
            2'b01:   count_next_s = count_r - CNT_W'(1);
            default: count_next_s = count_r;
        endcase
        peak_next_s = max_cnt(peak_r, count_next_s);
    end

    // Head-of-queue data, forced to zero while empty.
    always_comb begin
        out_value_s = {BITS{1'b0}};
        if (out_valid_s) begin
            out_value_s = mem_r[rd_ptr_r];
        end else begin
            out_value_s = {BITS{1'b0}};
        end
    end

    // Pointers, occupancy and peak; reset wins over any push or pop.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            peak_r   <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_next_s;
            peak_r  <= peak_next_s;
        end
    end

    // Storage array; contents survive reset since pointers define validity.
    always_ff @(posedge clock) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= bus.in_value;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_s;
    assign bus.out_value = out_value_s;
    assign bus.count     = count_r;
    assign bus.peak      = peak_r;
endmodule

// File: tb/tb_value_fifo.sv
// Directed scenarios plus random traffic on value_fifo, each cycle compared
// against a queue-based model of the FIFO.
module tb_value_fifo;
    localparam int BITS  = 8;
    localparam int DEPTH = 4;

    logic clock;
    logic reset;

    value_fifo_if #(.BITS(BITS), .DEPTH(DEPTH)) bus ();

    value_fifo #(.BITS(BITS), .DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int unsigned checks_r   = 0;
    int unsigned failures_r = 0;

    logic [BITS-1:0] model_q [$];
    int              peak_m   = 0;
    bit              last_push = 1'b0;
    bit              toggle_rd = 1'b0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks_r++;
        if (obs !== exp) begin
            failures_r++;
            $display("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: compare outputs at negedge, then advance the model over the posedge.
    task automatic step();
        bit do_push;
        bit do_pop;
        int head;
        @(negedge clock);
        head = (model_q.size() != 0) ? int'(model_q[0]) : 0;
        chk("count",     int'(bus.count),     model_q.size());
        chk("out_valid", int'(bus.out_valid), int'(model_q.size() != 0));
        chk("out_value", int'(bus.out_value), head);
        chk("in_ready",  int'(bus.in_ready),  int'(!reset && model_q.size() != DEPTH));
        chk("peak",      int'(bus.peak),      peak_m);
        do_push = bus.in_valid && !reset && (model_q.size() != DEPTH);
        do_pop  = bus.out_ready && !reset && (model_q.size() != 0);
        @(posedge clock);
        if (reset) begin
            model_q.delete();
            peak_m = 0;
        end else begin
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back(bus.in_value);
            if (model_q.size() > peak_m) peak_m = model_q.size();
        end
        last_push = do_push;
        #1;
        if (toggle_rd) bus.out_ready = ~bus.out_ready;
    endtask

    // Offer one value and hold it until accepted, within a cycle budget.
    task automatic send(input logic [BITS-1:0] v);
        int n;
        bus.in_value = v;
        bus.in_valid = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!last_push && n < 40);
        chk("send_accepted", int'(last_push), 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        reset         = 1'b1;
        bus.in_value  = 8'h00;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;

        // Reset then idle.
        idle(2);
        reset = 1'b0;
        idle(2);

        // Single pass-through.
        bus.out_ready = 1'b1;
        send(8'hA5);
        idle(3);
        chk("peak_after_pass", int'(bus.peak), 1);

        // Fill to full; fifth value held until a pop frees a slot.
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send(BITS'(i));
        bus.in_value = 8'h05;
        bus.in_valid = 1'b1;
        idle(2);
        chk("full_no_ready", int'(bus.in_ready), 0);
        bus.out_ready = 1'b1;
        step();
        chk("full_pop_no_push", int'(bus.count), 3);
        chk("full_pop_flag", int'(last_push), 0);
        send(8'h05);
        idle(6);
        chk("peak_full", int'(bus.peak), 4);

        // Wrap-around with out_ready toggling each cycle.
        toggle_rd = 1'b1;
        for (int i = 0; i < 10; i++) send(8'h10 + BITS'(i));
        toggle_rd = 1'b0;
        bus.out_ready = 1'b1;
        idle(6);

        // Streaming at count 2.
        bus.out_ready = 1'b0;
        send(8'h20);
        send(8'h21);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) send(8'h22 + BITS'(i));
        chk("stream_count", int'(bus.count), 2);
        idle(4);

        // Reset mid-stream at count 3.
        bus.out_ready = 1'b0;
        send(8'h30);
        send(8'h31);
        send(8'h32);
        chk("pre_reset_count", int'(bus.count), 3);
        reset         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        step();
        reset = 1'b0;
        bus.in_valid = 1'b0;
        chk("post_reset_count", int'(bus.count), 0);
        chk("post_reset_peak",  int'(bus.peak),  0);
        send(8'h77);
        chk("first_after_reset", int'(bus.out_value), 32'h77);
        idle(3);

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_value  = BITS'($urandom);
            bus.out_ready = 1'($urandom_range(0, 1));
            reset         = ($urandom_range(0, 63) == 0);
            step();
        end
        reset = 1'b0;
        bus.in_valid = 1'b0;
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
        $finish;
    end
endmodule
